countdown_timer_ssd: RTL and testbench



---
 rtl/timer_pkg.sv | 24 ++
 rtl/bcd7seg.sv | 26 ++
 rtl/countdown_timer_ssd.sv | 169 ++++++++++++++++
 tb/tb_countdown_timer_ssd.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared state type and seven-segment constants for countdown_timer_ssd
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Active-low patterns {a,b,c,d,e,f,g,dp}, dp always off
  localparam logic [7:0] SEG_0     = 8'h03;
  localparam logic [7:0] SEG_1     = 8'h9F;
  localparam logic [7:0] SEG_2     = 8'h25;
  localparam logic [7:0] SEG_3     = 8'h0D;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h49;
  localparam logic [7:0] SEG_6     = 8'h41;
  localparam logic [7:0] SEG_7     = 8'h1F;
  localparam logic [7:0] SEG_8     = 8'h01;
  localparam logic [7:0] SEG_9     = 8'h09;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

endpackage

// File: rtl/bcd7seg.sv
// rtl/bcd7seg.sv - combinational BCD digit to active-low seven-segment pattern
module bcd7seg
  import timer_pkg::*;
(
  input  logic [3:0] i_bcd,
  output logic [7:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    case (i_bcd)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/countdown_timer_ssd.sv
// rtl/countdown_timer_ssd.sv - N-digit BCD countdown timer with multiplexed SSD output
// Optional TIMER_DONE_BLINK_EN flashes the all-zero display while in DONE.
module countdown_timer_ssd
  import timer_pkg::*;
#(
  parameter int                      NUM_DIGITS = 2,
  parameter int                      TICK_DIV   = 50000000,
  parameter int                      SCAN_DIV   = 65536,
  parameter logic [4*NUM_DIGITS-1:0] START_BCD  = 'h30
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start_pause,
  input  logic                      load,
  input  logic [4*NUM_DIGITS-1:0]   preset,
  output logic [7:0]                seg,
  output logic [NUM_DIGITS-1:0]     an,
  output logic                      running,
  output logic                      done
);

  localparam int W  = 4 * NUM_DIGITS;
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  state_t                r_state, w_state_next;
  logic [W-1:0]          r_count, w_count_next, w_dec, w_clamped;
  logic [PW-1:0]         r_presc, w_presc_next;
  logic                  w_tick, w_borrow, w_blank;
  logic [SW-1:0]         r_scan_cnt;
  logic [IW-1:0]         r_idx;
  logic [3:0]            w_digit;
  logic [7:0]            w_seg_dec, r_seg;
  logic [NUM_DIGITS-1:0] w_an_scan, r_an;
  logic                  r_running, r_done;

  assign w_tick = (r_state == RUN) && (r_presc == PW'(TICK_DIV - 1));

  // Borrow ripples upward through zero digits; an all-zero count stays zero
  always_comb begin
    w_dec    = r_count;
    w_borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (w_borrow) begin
        if (r_count[4*i +: 4] == 4'd0) begin
          w_dec[4*i +: 4] = 4'd9;
        end else begin
          w_dec[4*i +: 4] = r_count[4*i +: 4] - 4'd1;
          w_borrow        = 1'b0;
        end
      end
    end
    if (r_count == '0) w_dec = '0;
  end

  always_comb begin
    w_clamped = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      w_clamped[4*i +: 4] = (preset[4*i +: 4] > 4'd9) ? 4'd9 : preset[4*i +: 4];
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_count_next = r_count;
    w_presc_next = r_presc;
    if (load) begin
      w_state_next = IDLE;
      w_count_next = w_clamped;
      w_presc_next = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start_pause && (r_count != '0)) begin
            w_state_next = RUN;
            w_presc_next = '0;
          end
        end
        RUN: begin
          w_presc_next = w_tick ? '0 : r_presc + PW'(1);
          if (w_tick) begin
            w_count_next = w_dec;
            if (w_dec == '0)      w_state_next = DONE;
            else if (start_pause) w_state_next = PAUSE;
          end else if (start_pause) begin
            w_state_next = PAUSE;
          end
        end
        PAUSE: begin
          if (start_pause) w_state_next = RUN;
        end
        default: begin
          w_state_next = DONE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_count <= START_BCD;
      r_presc <= '0;
    end else begin
      r_state <= w_state_next;
      r_count <= w_count_next;
      r_presc <= w_presc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_scan_cnt <= '0;
      r_idx      <= '0;
    end else if (r_scan_cnt == SW'(SCAN_DIV - 1)) begin
      r_scan_cnt <= '0;
      r_idx      <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
    end else begin
      r_scan_cnt <= r_scan_cnt + SW'(1);
    end
  end

  assign w_digit   = r_count[{r_idx, 2'b00} +: 4];
  assign w_an_scan = ~(NUM_DIGITS'(1) << r_idx);

  bcd7seg u_bcd7seg (
    .i_bcd (w_digit),
    .o_seg (w_seg_dec)
  );

`ifdef TIMER_DONE_BLINK_EN
  localparam int BW = $clog2(2 * TICK_DIV);
  logic [BW-1:0] r_blink;

  // Restarts on every DONE entry so the first half-period is blanked
  always_ff @(posedge clk) begin
    if (rst || (r_state != DONE)) begin
      r_blink <= '0;
    end else begin
      r_blink <= (r_blink == BW'(2 * TICK_DIV - 1)) ? '0 : r_blink + BW'(1);
    end
  end

  assign w_blank = (r_state == DONE) && (r_blink < BW'(TICK_DIV));
`else
  assign w_blank = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg     <= SEG_BLANK;
      r_an      <= '1;
      r_running <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_seg     <= w_seg_dec;
      r_an      <= w_blank ? '1 : w_an_scan;
      r_running <= (r_state == RUN);
      r_done    <= (r_state == DONE);
    end
  end

  assign seg     = r_seg;
  assign an      = r_an;
  assign running = r_running;
  assign done    = r_done;

endmodule

// File: tb/tb_countdown_timer_ssd.sv
// tb/tb_countdown_timer_ssd.sv - self-checking bench for countdown_timer_ssd with decimal reference model
module tb_countdown_timer_ssd;

  localparam int N  = 2;
  localparam int TD = 4;
  localparam int SD = 2;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start_pause = 1'b0;
  logic         load = 1'b0;
  logic [7:0]   preset = 8'h00;
  logic [7:0]   seg;
  logic [1:0]   an;
  logic         running;
  logic         done;

  int n_vec  = 0;
  int n_miss = 0;

  logic [7:0] seg_tab [10] = '{8'h03, 8'h9F, 8'h25, 8'h0D, 8'h99,
                               8'h49, 8'h41, 8'h1F, 8'h01, 8'h09};

  countdown_timer_ssd #(
    .NUM_DIGITS (N),
    .TICK_DIV   (TD),
    .SCAN_DIV   (SD),
    .START_BCD  (8'h30)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_pause (start_pause),
    .load        (load),
    .preset      (preset),
    .seg         (seg),
    .an          (an),
    .running     (running),
    .done        (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: count held as a decimal integer, phase = RUN cycles since last tick
  int         m_count, m_mode, m_phase, m_scan, m_blink, m_idx, m_dig;
  bit         m_valid = 1'b0;
  logic [7:0] e_seg;
  logic [1:0] e_an;
  logic       e_run, e_done;

  always @(posedge clk) begin
    if (rst) begin
      m_count = 30; m_mode = M_IDLE; m_phase = 0; m_scan = 0; m_blink = 0;
      e_seg = 8'hFF; e_an = 2'b11; e_run = 1'b0; e_done = 1'b0;
    end else begin
      m_idx = (m_scan / SD) % N;
      m_dig = (m_idx == 0) ? (m_count % 10) : ((m_count / 10) % 10);
      e_seg = seg_tab[m_dig];
      e_an  = (m_idx == 0) ? 2'b10 : 2'b01;
`ifdef TIMER_DONE_BLINK_EN
      if (m_mode == M_DONE && m_blink < TD) e_an = 2'b11;
`endif
      e_run  = (m_mode == M_RUN);
      e_done = (m_mode == M_DONE);
      m_scan++;
      if (m_mode == M_DONE) m_blink = (m_blink + 1) % (2 * TD);
      if (load) begin
        m_count = ((preset[7:4] > 9) ? 9 : int'(preset[7:4])) * 10
                + ((preset[3:0] > 9) ? 9 : int'(preset[3:0]));
        m_mode  = M_IDLE;
        m_phase = 0;
      end else if (m_mode == M_IDLE) begin
        if (start_pause && m_count != 0) begin m_mode = M_RUN; m_phase = 0; end
      end else if (m_mode == M_RUN) begin
        m_phase++;
        if (m_phase == TD) begin
          m_phase = 0;
          m_count--;
          if (m_count == 0) begin m_mode = M_DONE; m_blink = 0; end
          else if (start_pause) m_mode = M_PAUSE;
        end else if (start_pause) begin
          m_mode = M_PAUSE;
        end
      end else if (m_mode == M_PAUSE) begin
        if (start_pause) m_mode = M_RUN;
      end
    end
    m_valid = 1'b1;
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("seg", 32'(seg), 32'(e_seg));
      check("an", 32'(an), 32'(e_an));
      check("running", 32'(running), 32'(e_run));
      check("done", 32'(done), 32'(e_done));
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_sp();
    start_pause = 1'b1;
    cyc(1);
    start_pause = 1'b0;
  endtask

  task automatic do_load(input logic [7:0] v);
    preset = v;
    load   = 1'b1;
    cyc(1);
    load   = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    check("rst_seg", 32'(seg), 32'hFF);
    check("rst_an", 32'(an), 32'h3);
    check("rst_run", 32'(running), 32'h0);
    check("rst_done", 32'(done), 32'h0);
    rst = 1'b0;

    // Count 30 down to 00
    pulse_sp();
    cyc(3);
    check("cnt_30_hold", 32'(dut.r_count), 32'h30);
    cyc(1);
    check("cnt_29", 32'(dut.r_count), 32'h29);
    check("model_29", 32'(m_count), 32'd29);
    check("running_1", 32'(running), 32'h1);
    cyc(36);
    check("cnt_20", 32'(dut.r_count), 32'h20);
    cyc(4);
    check("cnt_19_borrow", 32'(dut.r_count), 32'h19);
    cyc(76);
    check("cnt_00", 32'(dut.r_count), 32'h00);
    check("done_late", 32'(done), 32'h0);
    cyc(1);
    check("done_1", 32'(done), 32'h1);
    check("running_0", 32'(running), 32'h0);
    pulse_sp();
    cyc(3);
    check("done_ignores_sp", 32'(done), 32'h1);
    check("model_done_00", 32'(m_count), 32'd0);

    // Pause at 25, hold, resume on remaining prescaler phase
    do_load(8'h30);
    pulse_sp();
    cyc(22);
    check("cnt_25", 32'(dut.r_count), 32'h25);
    pulse_sp();
    cyc(20);
    check("pause_hold", 32'(dut.r_count), 32'h25);
    check("pause_run0", 32'(running), 32'h0);
    pulse_sp();
    check("resume_25", 32'(dut.r_count), 32'h25);
    cyc(1);
    check("resume_24", 32'(dut.r_count), 32'h24);

    // Load with clamp, coincident start_pause ignored
    preset = 8'h9C; load = 1'b1; start_pause = 1'b1;
    cyc(1);
    load = 1'b0; start_pause = 1'b0;
    check("load_clamp", 32'(dut.r_count), 32'h99);
    cyc(1);
    check("load_run0", 32'(running), 32'h0);
    cyc(8);
    check("load_idle_hold", 32'(dut.r_count), 32'h99);

    // Zero preset cannot start
    do_load(8'h00);
    pulse_sp();
    cyc(2);
    check("zero_run", 32'(running), 32'h0);
    check("zero_done", 32'(done), 32'h0);

    // Scan pattern on "30"
    do_load(8'h30);
    cyc(2);
    for (int k = 0; k < 8; k++) begin
      if (an == 2'b10) begin
        check("scan_d0", 32'(seg), 32'h03);
      end else begin
        check("scan_an", 32'(an), 32'h1);
        check("scan_d1", 32'(seg), 32'h0D);
      end
      cyc(1);
    end

    // Reset mid-run
    pulse_sp();
    cyc(6);
    rst = 1'b1;
    cyc(1);
    check("mrst_seg", 32'(seg), 32'hFF);
    check("mrst_an", 32'(an), 32'h3);
    check("mrst_cnt", 32'(dut.r_count), 32'h30);
    check("mrst_run", 32'(running), 32'h0);
    rst = 1'b0;
    cyc(2);

    // DONE display behaviour
    do_load(8'h02);
    pulse_sp();
    cyc(8);
    check("d2_zero", 32'(dut.r_count), 32'h00);
    cyc(1);
    for (int k = 0; k < 8; k++) begin
`ifdef TIMER_DONE_BLINK_EN
      check("blink", 32'(an == 2'b11), 32'(k < 4));
`else
      check("steady", 32'(an == 2'b11), 32'h0);
`endif
      cyc(1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
